// File: rtl/if_stage_if.sv
// Fetch-stage bundle: decode handshake, branch redirect and inst SRAM port.
// master = if_stage side, slave = decode/SRAM side.
// BUS_W defaults to 65 when IF_ADEF_CHECK_EN is defined, else 64.
interface if_stage_if #(
`ifdef IF_ADEF_CHECK_EN
    parameter int BUS_W = 65
`else
    parameter int BUS_W = 64
`endif
);
    logic             ds_allowin;
    logic [32:0]      br_bus;
    logic             fs_to_ds_valid;
    logic [BUS_W-1:0] fs_to_ds_bus;
    logic             inst_sram_en;
    logic [3:0]       inst_sram_we;
    logic [31:0]      inst_sram_addr;
    logic [31:0]      inst_sram_wdata;
    logic [31:0]      inst_sram_rdata;

    modport master (
        input  ds_allowin, br_bus, inst_sram_rdata,
        output fs_to_ds_valid, fs_to_ds_bus,
               inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output ds_allowin, br_bus, inst_sram_rdata,
        input  fs_to_ds_valid, fs_to_ds_bus,
               inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage (pre-IF + IF). Owns the PC, drives the
// synchronous-read inst SRAM, handles decode redirects and buffers the
// fetched word while decode stalls.
// Optional macro IF_ADEF_CHECK_EN: flags misaligned fetch addresses (adef),
// suppresses the SRAM read and reports inst as zero; bus grows to 65 bits.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
`ifdef IF_ADEF_CHECK_EN
    parameter int BUS_W = 65
`else
    parameter int BUS_W = 64
`endif
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master fs
);
    logic        br_taken;
    logic [31:0] br_target;

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        buf_valid;
    logic [31:0] inst_buf;
    logic        br_pend;
    logic [31:0] pend_target;
    logic        cancel_q;

    logic        to_fs_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        fs_accept;
    logic        buf_load;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;
    logic [BUS_W-1:0] bus_int;

    assign {br_taken, br_target} = fs.br_bus;

    // ---- pre-IF: next fetch address ----
    assign to_fs_valid = ~reset;
    assign seq_pc      = fs_pc + 32'd4;
    assign nextpc      = br_taken ? br_target :
                         br_pend  ? pend_target : seq_pc;

    // ---- IF: handshake with decode ----
    assign fs_ready_go = 1'b1;
    assign fs_allowin  = ~fs_valid | (fs_ready_go & fs.ds_allowin);
    assign fs_accept   = to_fs_valid & fs_allowin;
    // Capture the SRAM word on the first stalled cycle; SRAM output is
    // not trusted afterwards.
    assign buf_load    = fs_valid & ~fs.ds_allowin & ~buf_valid;
    assign fs_inst     = buf_valid ? inst_buf : fs.inst_sram_rdata;

    assign fs.fs_to_ds_valid  = fs_valid & ~br_taken & ~cancel_q;
    assign fs.inst_sram_we    = 4'h0;
    assign fs.inst_sram_wdata = 32'h0;
    assign fs.inst_sram_addr  = nextpc;

`ifdef IF_ADEF_CHECK_EN
    logic misalign;
    logic adef_q;

    assign misalign        = |nextpc[1:0];
    assign fs.inst_sram_en = fs_accept & ~misalign;
    assign bus_int         = {adef_q, (adef_q ? 32'h0 : fs_inst), fs_pc};

    // Address-error flag follows the fetch it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adef_q <= 1'b0;
        end else if (fs_accept) begin
            adef_q <= misalign;
        end
    end
`else
    assign fs.inst_sram_en = fs_accept;
    assign bus_int         = {fs_inst, fs_pc};
`endif

    assign fs.fs_to_ds_bus = bus_int;

    // IF control state: valid, PC, buffer flag, pending redirect, cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_valid  <= 1'b0;
            fs_pc     <= RESET_PC - 32'd4;
            buf_valid <= 1'b0;
            br_pend   <= 1'b0;
            cancel_q  <= 1'b0;
        end else if (fs_accept) begin
            fs_valid  <= 1'b1;
            fs_pc     <= nextpc;
            buf_valid <= 1'b0;
            br_pend   <= 1'b0;
            cancel_q  <= 1'b0;
        end else begin
            // Stalled: remember redirect and kill the held instruction.
            if (br_taken) begin
                br_pend  <= 1'b1;
                cancel_q <= 1'b1;
            end
            if (buf_load) begin
                buf_valid <= 1'b1;
            end
        end
    end

    // Data holding registers (no reset; qualified by their control flags).
    always_ff @(posedge clk) begin
        if (~fs_accept & br_taken) begin
            pend_target <= br_target;
        end
        if (buf_load) begin
            inst_buf <= fs.inst_sram_rdata;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural synchronous-read SRAM.
// SRAM word at address a is 0x02800021 + (a[11:0] << 8); when not read it
// returns 0xdeadbeef so stale data is visible.
module tb_if_stage;
`ifdef IF_ADEF_CHECK_EN
    localparam int BUS_W = 65;
`else
    localparam int BUS_W = 64;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    if_stage_if #(.BUS_W(BUS_W)) fs_if ();

    if_stage #(.RESET_PC(32'h1c000000), .BUS_W(BUS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .fs    (fs_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h02800021 + {12'h0, a[11:0], 8'h0};
    endfunction

    always @(posedge clk) begin
        fs_if.inst_sram_rdata <= fs_if.inst_sram_en ? word(fs_if.inst_sram_addr) : 32'hdeadbeef;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        fs_if.ds_allowin = 1'b1;
        fs_if.br_bus = 33'h0;
        #2;
        chk("rst_valid", fs_if.fs_to_ds_valid, 0);
        chk("rst_en", fs_if.inst_sram_en, 0);
        chk("rst_we", fs_if.inst_sram_we, 0);
        chk("rst_wdata", fs_if.inst_sram_wdata, 0);
        step(); step();
        // Release reset: first fetch
        reset = 1'b0;
        #1;
        chk("c1_addr", fs_if.inst_sram_addr, 32'h1c000000);
        chk("c1_en", fs_if.inst_sram_en, 1);
        chk("c1_valid", fs_if.fs_to_ds_valid, 0);
        step(); #1;
        chk("c2_valid", fs_if.fs_to_ds_valid, 1);
        chk("c2_bus", fs_if.fs_to_ds_bus, {32'h02800021, 32'h1c000000});
        chk("c2_addr", fs_if.inst_sram_addr, 32'h1c000004);
        step(); #1;
        chk("c3_bus", fs_if.fs_to_ds_bus, {32'h02800421, 32'h1c000004});
        // Decode stall for three cycles
        fs_if.ds_allowin = 1'b0; #1;
        chk("st1_en", fs_if.inst_sram_en, 0);
        chk("st1_valid", fs_if.fs_to_ds_valid, 1);
        step(); #1;
        chk("st2_en", fs_if.inst_sram_en, 0);
        chk("st2_bus", fs_if.fs_to_ds_bus, {32'h02800421, 32'h1c000004});
        step(); #1;
        chk("st3_bus", fs_if.fs_to_ds_bus, {32'h02800421, 32'h1c000004});
        chk("st3_valid", fs_if.fs_to_ds_valid, 1);
        step();
        fs_if.ds_allowin = 1'b1; #1;
        chk("rel_bus", fs_if.fs_to_ds_bus, {32'h02800421, 32'h1c000004});
        chk("rel_addr", fs_if.inst_sram_addr, 32'h1c000008);
        chk("rel_en", fs_if.inst_sram_en, 1);
        step(); #1;
        chk("c8_bus", fs_if.fs_to_ds_bus, {32'h02800821, 32'h1c000008});
        // Branch with decode accepting
        fs_if.br_bus = {1'b1, 32'h1c000100}; #1;
        chk("br_valid", fs_if.fs_to_ds_valid, 0);
        chk("br_addr", fs_if.inst_sram_addr, 32'h1c000100);
        chk("br_en", fs_if.inst_sram_en, 1);
        step();
        fs_if.br_bus = 33'h0;
        fs_if.ds_allowin = 1'b0; #1;
        chk("brt_valid", fs_if.fs_to_ds_valid, 1);
        chk("brt_bus", fs_if.fs_to_ds_bus, {32'h02810021, 32'h1c000100});
        chk("brt_en", fs_if.inst_sram_en, 0);
        // Two redirects during a stall; the newer wins
        step();
        fs_if.br_bus = {1'b1, 32'h1c000180}; #1;
        chk("sb1_valid", fs_if.fs_to_ds_valid, 0);
        chk("sb1_en", fs_if.inst_sram_en, 0);
        step();
        fs_if.br_bus = {1'b1, 32'h1c000200}; #1;
        chk("sb2_valid", fs_if.fs_to_ds_valid, 0);
        step();
        fs_if.br_bus = 33'h0;
        fs_if.ds_allowin = 1'b1; #1;
        chk("sb3_cancel", fs_if.fs_to_ds_valid, 0);
        chk("sb3_addr", fs_if.inst_sram_addr, 32'h1c000200);
        chk("sb3_en", fs_if.inst_sram_en, 1);
        step(); #1;
        chk("sb4_valid", fs_if.fs_to_ds_valid, 1);
        chk("sb4_bus", fs_if.fs_to_ds_bus, {32'h02820021, 32'h1c000200});
        // Pending redirect, then asynchronous reset mid-stall
        fs_if.ds_allowin = 1'b0;
        fs_if.br_bus = {1'b1, 32'h1c000300};
        step();
        fs_if.br_bus = 33'h0; #1;
        chk("pr_cancel", fs_if.fs_to_ds_valid, 0);
        chk("pr_addr", fs_if.inst_sram_addr, 32'h1c000300);
        reset = 1'b1; #1;
        chk("ar_en", fs_if.inst_sram_en, 0);
        chk("ar_valid", fs_if.fs_to_ds_valid, 0);
        chk("ar_addr", fs_if.inst_sram_addr, 32'h1c000000);
        step();
        reset = 1'b0; #1;
        chk("rr_addr", fs_if.inst_sram_addr, 32'h1c000000);
        chk("rr_en", fs_if.inst_sram_en, 1);
        step();
        fs_if.ds_allowin = 1'b1; #1;
        chk("rr_valid", fs_if.fs_to_ds_valid, 1);
        chk("rr_bus", fs_if.fs_to_ds_bus, {32'h02800021, 32'h1c000000});
        // PC wrap at 2^32
        fs_if.br_bus = {1'b1, 32'hfffffffc}; #1;
        chk("wr_addr", fs_if.inst_sram_addr, 32'hfffffffc);
        step();
        fs_if.br_bus = 33'h0; #1;
        chk("wr_bus", fs_if.fs_to_ds_bus, {32'h028ffc21, 32'hfffffffc});
        chk("wr_next", fs_if.inst_sram_addr, 32'h0);
        step(); #1;
        chk("wr_bus0", fs_if.fs_to_ds_bus, {32'h02800021, 32'h0});
        chk("wr_next4", fs_if.inst_sram_addr, 32'h4);
`ifdef IF_ADEF_CHECK_EN
        // Misaligned branch target raises adef
        fs_if.br_bus = {1'b1, 32'h1c000102}; #1;
        chk("ad_en", fs_if.inst_sram_en, 0);
        chk("ad_addr", fs_if.inst_sram_addr, 32'h1c000102);
        step();
        fs_if.br_bus = 33'h0; #1;
        chk("ad_valid", fs_if.fs_to_ds_valid, 1);
        chk("ad_bus", fs_if.fs_to_ds_bus, {1'b1, 32'h0, 32'h1c000102});
        fs_if.br_bus = {1'b1, 32'h1c000400}; #1;
        chk("ad_fix_en", fs_if.inst_sram_en, 1);
        step();
        fs_if.br_bus = 33'h0; #1;
        chk("ad_clr_bus", fs_if.fs_to_ds_bus, {1'b0, 32'h02840021, 32'h1c000400});
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
